// File: rtl/uart_pkg.sv
// uart_pkg: types shared by the UART transmitter and receiver.
// Holds the FSM state enum, parity-type constants and the default word width.
package uart_pkg;

    localparam int DEF_DATA_WIDTH = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// uart_tx_bit_timer: prescale counter that pulses bit_done on the last cycle of each bit.
// Ports: CLK, RST, load (latch prescale, restart), run (count enable), prescale, bit_done.
module uart_tx_bit_timer #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic                  run,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  bit_done
);

    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] period_q;
    logic [PRESCALE_W-1:0] cnt_q;

    assign bit_done = run && (cnt_q == period_q - ONE);

    // A prescale of zero is stretched to one cycle per bit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            period_q <= ONE;
            cnt_q    <= '0;
        end else if (load) begin
            period_q <= (prescale == '0) ? ONE : prescale;
            cnt_q    <= '0;
        end else if (!run || bit_done) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + ONE;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter, start / data LSB first / optional parity / stop.
// Ports: CLK, RST, P_DATA, DATA_VALID, PAR_EN, PAR_TYP, Prescale in; TX_OUT, BUSY out.
// Define UART_TX_TWO_STOP_EN for two stop bits; default build sends one.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic                  TX_OUT,
    output logic                  BUSY
);

`ifdef UART_TX_TWO_STOP_EN
    localparam int STOP_BITS = 2;
`else
    localparam int STOP_BITS = 1;
`endif

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

    uart_state_e           state_q, state_n;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_n;
    logic [CW-1:0]         cnt_q, cnt_n;
    logic                  par_q, par_n;
    logic                  par_en_q, par_en_n;
    logic                  tx_q, tx_n;
    logic                  busy_q, busy_n;
    logic                  accept;
    logic                  bit_done;

    uart_tx_bit_timer #(
        .PRESCALE_W(PRESCALE_W)
    ) u_timer (
        .CLK     (CLK),
        .RST     (RST),
        .load    (accept),
        .run     (state_q != IDLE),
        .prescale(Prescale),
        .bit_done(bit_done)
    );

    // cnt_q indexes data bits in DATA and stop bits in STOP.
    // tx_n is the line level for the cycle after the edge, so TX_OUT is a flop.
    always_comb begin
        state_n  = state_q;
        shreg_n  = shreg_q;
        cnt_n    = cnt_q;
        par_n    = par_q;
        par_en_n = par_en_q;
        tx_n     = tx_q;
        busy_n   = busy_q;
        accept   = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_n   = 1'b1;
                busy_n = 1'b0;
                if (DATA_VALID) begin
                    accept   = 1'b1;
                    state_n  = START;
                    shreg_n  = P_DATA;
                    par_n    = (^P_DATA) ^ (PAR_TYP == PAR_ODD);
                    par_en_n = PAR_EN;
                    tx_n     = 1'b0;
                    busy_n   = 1'b1;
                end
            end
            START: begin
                if (bit_done) begin
                    state_n = DATA;
                    cnt_n   = '0;
                    tx_n    = shreg_q[0];
                    shreg_n = shreg_q >> 1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (cnt_q == LAST_BIT) begin
                        cnt_n = '0;
                        if (par_en_q) begin
                            state_n = PARITY;
                            tx_n    = par_q;
                        end else begin
                            state_n = STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        cnt_n   = cnt_q + 1'b1;
                        tx_n    = shreg_q[0];
                        shreg_n = shreg_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_n = STOP;
                    cnt_n   = '0;
                    tx_n    = 1'b1;
                end
            end
            STOP: begin
                tx_n = 1'b1;
                if (bit_done) begin
                    if (cnt_q == LAST_STOP) begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            shreg_q  <= shreg_n;
            cnt_q    <= cnt_n;
            par_q    <= par_n;
            par_en_q <= par_en_n;
            tx_q     <= tx_n;
            busy_q   <= busy_n;
        end
    end

    assign TX_OUT = tx_q;
    assign BUSY   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: scoreboard bench for uart_tx_frame.
// Stimulus pushes expected frames; a monitor decodes TX_OUT/BUSY per cycle.
module tb_uart_tx_frame;

`ifdef UART_TX_TWO_STOP_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif
    localparam int NFRAMES = 13;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       par;
        logic [6:0] w;
    } item_t;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic       TX_OUT;
    logic       BUSY;

    item_t sb[$];
    int    total = 0;
    int    bad   = 0;
    int    fno   = 0;

    uart_tx_frame dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .DATA_VALID(DATA_VALID),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .Prescale  (Prescale),
        .TX_OUT    (TX_OUT),
        .BUSY      (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic exp_bit(input item_t it, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return it.d[b-1];
        if (b == 9 && it.pe) return it.par;
        return 1'b1;
    endfunction

    task automatic wait_idle(input string nm);
        int n = 0;
        while (BUSY !== 1'b0 && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        if (BUSY !== 1'b0) chk({nm, "_idle_timeout"}, 32'(BUSY), 0);
    endtask

    // Returns at the first frame cycle, with inputs scrambled.
    task automatic send(input logic [7:0] d, input logic pe,
                        input logic pt, input logic [5:0] p,
                        input int w, input logic par);
        item_t it;
        wait_idle("send");
        it.d   = d;
        it.pe  = pe;
        it.par = par;
        it.w   = 7'(w);
        sb.push_back(it);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Prescale   = p;
        DATA_VALID = 1'b1;
        @(negedge CLK);
        DATA_VALID = 1'b0;
        P_DATA     = ~d;
        PAR_EN     = ~pe;
        PAR_TYP    = ~pt;
        Prescale   = p + 6'd3;
    endtask

    initial begin : monitor
        item_t      it;
        logic       prev_busy;
        logic       e;
        logic [1:0] seen;
        int         nb, b, k, badc;
        bit         aborted;
        prev_busy = 1'b0;
        forever begin
            @(negedge CLK);
            if (BUSY === 1'b1 && !prev_busy && !RST) begin
                if (sb.size() == 0) begin
                    chk("unexpected_frame", 32'(BUSY), 0);
                end else begin
                    it      = sb.pop_front();
                    nb      = 9 + int'(it.pe) + NSTOP;
                    aborted = 0;
                    b       = 0;
                    while (b < nb && !aborted) begin
                        e    = exp_bit(it, b);
                        seen = {1'b1, e};
                        badc = 0;
                        k    = 0;
                        while (k < int'(it.w) && !aborted) begin
                            if (!(b == 0 && k == 0)) @(negedge CLK);
                            if (RST) begin
                                aborted = 1;
                            end else if ({BUSY, TX_OUT} !== {1'b1, e}) begin
                                if (badc == 0) seen = {BUSY, TX_OUT};
                                badc++;
                            end
                            k++;
                        end
                        if (!aborted)
                            chk($sformatf("frame%0d_bit%0d", fno, b),
                                32'(seen), 32'({1'b1, e}));
                        b++;
                    end
                    if (!aborted) begin
                        @(negedge CLK);
                        chk($sformatf("frame%0d_end", fno),
                            32'({BUSY, TX_OUT}), 32'(2'b01));
                    end
                    fno++;
                end
            end
            prev_busy = BUSY;
        end
    end

    initial begin : watchdog
        repeat (50000) @(posedge CLK);
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        RST        = 1'b1;
        P_DATA     = '0;
        DATA_VALID = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        Prescale   = 6'd16;
        repeat (3) @(negedge CLK);
        chk("rst_tx", 32'(TX_OUT), 1);
        chk("rst_busy", 32'(BUSY), 0);
        RST = 1'b0;
        @(negedge CLK);
        chk("idle_tx", 32'(TX_OUT), 1);

        // 0xA5 odd parity; a 0x11 request mid-frame must be dropped.
        send(8'hA5, 1'b1, 1'b1, 6'd16, 16, 1'b1);
        repeat (40) @(negedge CLK);
        P_DATA     = 8'h11;
        DATA_VALID = 1'b1;
        @(negedge CLK);
        DATA_VALID = 1'b0;

        send(8'hA5, 1'b1, 1'b0, 6'd16, 16, 1'b0);
        send(8'hA5, 1'b0, 1'b0, 6'd16, 16, 1'b0);
        send(8'h00, 1'b1, 1'b1, 6'd4,  4,  1'b1);
        send(8'hFF, 1'b1, 1'b0, 6'd4,  4,  1'b0);
        send(8'h3C, 1'b1, 1'b1, 6'd3,  3,  1'b1);
        send(8'h3C, 1'b1, 1'b0, 6'd2,  2,  1'b0);
        send(8'hFF, 1'b1, 1'b1, 6'd1,  1,  1'b1);
        send(8'h00, 1'b1, 1'b0, 6'd5,  5,  1'b0);
        send(8'h81, 1'b0, 1'b0, 6'd0,  1,  1'b0);
        send(8'h5A, 1'b1, 1'b1, 6'd63, 63, 1'b1);

        // Abort during data bit 3 (frame bit 4), then a clean 0x5A.
        send(8'hA5, 1'b1, 1'b0, 6'd8, 8, 1'b0);
        repeat (4 * 8 + 4) @(negedge CLK);
        #1 RST = 1'b1;
        #1;
        chk("midrst_tx", 32'(TX_OUT), 1);
        chk("midrst_busy", 32'(BUSY), 0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("postrst_tx", 32'(TX_OUT), 1);
        chk("postrst_busy", 32'(BUSY), 0);
        send(8'h5A, 1'b1, 1'b0, 6'd8, 8, 1'b0);

        wait_idle("final");
        repeat (10) @(negedge CLK);
        chk("sb_empty", 32'(sb.size()), 0);
        chk("frames_seen", 32'(fno), NFRAMES);
        chk("final_line", 32'({BUSY, TX_OUT}), 32'(2'b01));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
